fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Instruction fetch stage sitting directly upstream of the fetch/decode pipeline register. It owns the program counter, issues pipelined read requests to the instruction memory over a request/response handshake, and buffers returned instructions in a small in-order queue. It presents one instruction plus its PC+4 per cycle to fetch/decode, holds under hazard-unit stall, and flushes cleanly on a branch/jump redirect.

## Interface
- DEPTH, 4: queue entries; also the maximum number of outstanding memory requests (power of two, ≥2)
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, no earlier than the cycle after acceptance
- imem_rdata  in  32  returned instruction
- redirect  in  1  branch/jump taken; single-cycle pulse
- redirect_pc  in  32  new fetch address (word-aligned)
- stall  in  1  hazard-unit stall; the head entry is held
- fd_valid  out  1  head entry valid
- fd_instr  out  32  head instruction; 32'h0 when fd_valid=0
- fd_pc4  out  32  address of the head instruction + 4; 32'h0 when fd_valid=0

## Operation
- Registers: fetch_pc (32), queue of DEPTH entries {instr, pc4} with read/write pointers and count, outstanding counter (log2(DEPTH)+1 bits), drop counter (same width), FSM state.
- The queue stores pc4 = request address + 4. The request address is carried through a DEPTH-entry in-order address FIFO alongside the outstanding requests.
- FSM RUN: imem_req = (count + outstanding < DEPTH) && !redirect. imem_addr = fetch_pc. Acceptance (imem_req && imem_ready) increments outstanding and sets fetch_pc += 4, wrapping modulo 2^32.
- Response in RUN: imem_rvalid writes {imem_rdata, addr+4} to the queue tail and decrements outstanding.
- Pop: fd_valid && !stall && !redirect removes the head. A push and a pop in the same cycle leave count unchanged. Full is impossible because of the issue credit rule; if imem_rvalid arrives with nothing outstanding, it is ignored.
- Redirect in any state:
  - queue cleared (count=0), fetch_pc := redirect_pc, no request issued that cycle.
  - drop := outstanding minus any response accepted in the same cycle (that response is discarded).
  - State becomes DRAIN if the resulting drop > 0, else RUN.
- FSM DRAIN: imem_req=0. Each imem_rvalid is discarded and decrements drop. When drop reaches 0 (including on the cycle of the last discarded response), next state is RUN. A redirect during DRAIN reloads fetch_pc, drop stays equal to the remaining outstanding, and the state remains DRAIN.
- Redirect has priority over stall. Stall never blocks issue or fill.

## Timing
- Reset (reset=0, asynchronous): state=RUN, fetch_pc=RESET_PC, count/outstanding/drop=0, imem_req=0, imem_addr=RESET_PC, fd_valid=0, fd_instr=0, fd_pc4=0.
- First imem_req is in the first cycle after reset deasserts.
- All fd_* outputs are registered/queue-head driven. A response in cycle N is visible on fd_* in cycle N+1.
- Minimum latency from acceptance to fd_valid is 2 cycles. With a 1-cycle memory and no stall, sustained throughput is 1 instruction/cycle.
- After redirect in cycle N with zero outstanding: imem_req=1 with imem_addr=redirect_pc in N+1.
- fd_valid=0 from N+1 until the first new response lands.
- Reset asserted mid-DRAIN or mid-burst returns all state to the reset values immediately. Stale responses arriving after reset with outstanding=0 are ignored.

## Test plan
- Streaming: reset, 1-cycle memory returning imem_rdata=addr, no stall → fd_instr = 0,4,8,… on consecutive cycles from cycle 3; fd_pc4 = fd_instr+4.
- Backpressure: stall held 6 cycles with DEPTH=4 → queue fills, imem_req drops after 4 credits, fd_instr holds a constant value, no entry is lost or duplicated after release.
- Redirect with 3 outstanding, memory latency 3: redirect_pc=0x100 → the 3 stale responses are discarded, FSM goes DRAIN→RUN, next fd_instr=0x100, fd_pc4=0x104.
- Redirect and imem_rvalid in the same cycle with stall=1 → the response is discarded, fd_valid=0 the next cycle, and the stall has no effect on the flush.
- Wrap: redirect_pc=0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000; fd_pc4=0x0000_0000 then 0x0000_0004.
- Async reset asserted during DRAIN → all outputs are at reset values in the same cycle, first imem_addr after release = RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction fetch stage. Owns the PC, issues pipelined
// reads to instruction memory under a credit limit, and buffers responses in an
// in-order queue whose head feeds the fetch/decode pipeline register.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] CREDIT_LIMIT = SW'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_instr   [DEPTH];
  logic [31:0]   q_pc4     [DEPTH];
  logic [31:0]   addr_fifo [DEPTH];
  logic [PW-1:0] q_rd;
  logic [PW-1:0] q_wr;
  logic [PW-1:0] a_rd;
  logic [PW-1:0] a_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;
  logic          resp_dec;
  logic [SW-1:0] credit_used;
  logic [CW-1:0] drop_src;
  logic [CW-1:0] drop_next;

  // Issue credit, handshake decode, and the drop count a redirect would leave behind
  always_comb begin
    credit_used = {1'b0, count} + {1'b0, outstanding};
    imem_req    = reset && (state == RUN) && (credit_used < CREDIT_LIMIT) && !redirect;
    imem_addr   = fetch_pc;
    accept      = imem_req && imem_ready;
    resp        = imem_rvalid && (state == RUN) && (outstanding != '0);
    push        = resp && !redirect;
    pop         = fd_valid && !stall && !redirect;
    drop_src    = (state == DRAIN) ? drop : outstanding;
    resp_dec    = imem_rvalid && (drop_src != '0);
    drop_next   = drop_src - {{(CW-1){1'b0}}, resp_dec};
  end

  // Queue head drives fetch/decode directly and reads as zero when empty
  always_comb begin
    fd_valid = (count != '0);
    fd_instr = fd_valid ? q_instr[q_rd] : 32'h0;
    fd_pc4   = fd_valid ? q_pc4[q_rd]   : 32'h0;
  end

  // Storage needs no reset: entry validity lives entirely in the pointers and counts
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_fifo[a_wr] <= fetch_pc;
    end
    if (push) begin
      q_instr[q_wr] <= imem_rdata;
      q_pc4[q_wr]   <= addr_fifo[a_rd] + 32'd4;
    end
  end

  // Fetch control: PC, credit counters, pointers and the RUN/DRAIN flush machine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      a_rd        <= '0;
      a_wr        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      q_rd        <= '0;
      q_wr        <= '0;
      a_rd        <= '0;
      a_wr        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= drop_next;
      state       <= (drop_next != '0) ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      if (imem_rvalid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if ((drop == '0) || (imem_rvalid && (drop == CW'(1)))) begin
        state <= RUN;
      end
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        a_wr     <= a_wr + PW'(1);
      end
      if (resp) begin
        a_rd <= a_rd + PW'(1);
      end
      if (push) begin
        q_wr <= q_wr + PW'(1);
      end
      if (pop) begin
        q_rd <= q_rd + PW'(1);
      end
      case ({accept, resp})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: drives fetch_prefetch_queue with an in-order memory
// model of random latency. Every accepted fetch pushes the instruction the
// pipeline should eventually see into a scoreboard; a monitor compares the
// queue head against it. Redirect and reset discard everything still pending.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc4;

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .fd_valid    (fd_valid),
    .fd_instr    (fd_instr),
    .fd_pc4      (fd_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          ready_at;
    bit          stale;
  } mem_entry_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_entry_t;

  mem_entry_t  mem_q[$];
  exp_entry_t  sb[$];
  logic [31:0] model_pc;
  logic [31:0] salt;
  int          cycle;
  int          n_compared;
  int          n_mismatched;
  int          ready_pct;
  int          lat_min;
  int          lat_max;
  int          expect_valid;
  bit          inject_stale;
  bit          in_reset;
  bit          prev_redirect;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
               name, cycle, actual, expected);
    end
  endtask

  function automatic int count_stale();
    int n = 0;
    foreach (mem_q[i]) begin
      if (mem_q[i].stale) n++;
    end
    return n;
  endfunction

  // One clock cycle: drive inputs after the rising edge, check and update the model mid-cycle
  task automatic apply_stimulus(input bit redir, input logic [31:0] rpc, input bit stl);
    bit         resp_from_q;
    bit         exp_req;
    int         sb_snap;
    int         stale_snap;
    int         lat;
    mem_entry_t me;
    exp_entry_t ee;
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    imem_ready  = ($urandom_range(99) < ready_pct);
    resp_from_q = (mem_q.size() > 0) && (mem_q[0].ready_at <= cycle);
    if (resp_from_q) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else if (inject_stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    inject_stale = 1'b0;
    sb_snap    = sb.size();
    stale_snap = count_stale();
    @(negedge clk);
    #1;
    exp_req = (stale_snap == 0) && (sb_snap < DEPTH) && !redir;
    check_output("imem_req", imem_req, exp_req);
    check_output("imem_addr", imem_addr, model_pc);
    if (expect_valid >= 0) begin
      check_output("stream_valid", fd_valid, expect_valid[0]);
    end
    if (resp_from_q) begin
      void'(mem_q.pop_front());
    end
    if (imem_req && imem_ready) begin
      lat         = $urandom_range(lat_max, lat_min);
      me.data     = model_pc ^ salt;
      me.ready_at = cycle + lat;
      me.stale    = 1'b0;
      mem_q.push_back(me);
      ee.instr    = model_pc ^ salt;
      ee.pc4      = model_pc + 32'd4;
      sb.push_back(ee);
      model_pc    = model_pc + 32'd4;
    end
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      sb.delete();
      model_pc = rpc;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Assert reset just after an edge, check outputs immediately, release after hold cycles
  task automatic do_reset(input int hold);
    in_reset    = 1'b1;
    reset       = 1'b0;
    redirect    = 1'b0;
    stall       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_output("rst_imem_req", imem_req, 32'h0);
    check_output("rst_imem_addr", imem_addr, RESET_PC);
    check_output("rst_fd_valid", fd_valid, 32'h0);
    check_output("rst_fd_instr", fd_instr, 32'h0);
    check_output("rst_fd_pc4", fd_pc4, 32'h0);
    mem_q.delete();
    sb.delete();
    model_pc = RESET_PC;
    repeat (hold) @(posedge clk);
    #1;
    reset    = 1'b1;
    in_reset = 1'b0;
    cycle    = 1;
  endtask

  // Monitor: compare the queue head against the scoreboard and retire it on a pop
  always @(negedge clk) begin
    if (in_reset) begin
      prev_redirect = 1'b0;
    end else begin
      if (prev_redirect) begin
        check_output("valid_after_redirect", fd_valid, 32'h0);
      end
      if (fd_valid) begin
        if (sb.size() == 0) begin
          check_output("fd_valid_unexpected", fd_valid, 32'h0);
        end else begin
          check_output("fd_instr", fd_instr, sb[0].instr);
          check_output("fd_pc4", fd_pc4, sb[0].pc4);
          if (!stall && !redirect) void'(sb.pop_front());
        end
      end else begin
        check_output("idle_instr", fd_instr, 32'h0);
        check_output("idle_pc4", fd_pc4, 32'h0);
      end
      prev_redirect = redirect;
    end
  end

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    cycle         = 0;
    in_reset      = 1'b1;
    prev_redirect = 1'b0;
    reset         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    stall         = 1'b0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    ready_pct     = 100;
    lat_min       = 1;
    lat_max       = 1;
    salt          = 32'h0;
    expect_valid  = -1;
    inject_stale  = 1'b0;
    model_pc      = RESET_PC;
    @(posedge clk);
    #1;
    do_reset(2);

    $display("[TB] streaming with 1-cycle memory");
    for (int i = 0; i < 16; i++) begin
      expect_valid = (cycle >= 3) ? 1 : 0;
      apply_stimulus(1'b0, 32'h0, 1'b0);
    end
    expect_valid = -1;

    $display("[TB] backpressure: stall held 6 cycles");
    repeat (6) apply_stimulus(1'b0, 32'h0, 1'b1);
    repeat (10) apply_stimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] redirect with outstanding requests, latency 3");
    lat_min = 3;
    lat_max = 3;
    repeat (8) apply_stimulus(1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h0000_0100, 1'b0);
    repeat (14) apply_stimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] redirect coinciding with a response under stall");
    lat_min = 1;
    lat_max = 1;
    repeat (6) apply_stimulus(1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h0000_0200, 1'b1);
    repeat (2) apply_stimulus(1'b0, 32'h0, 1'b1);
    repeat (8) apply_stimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] address wrap");
    apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (10) apply_stimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] reset during drain");
    lat_min = 3;
    lat_max = 3;
    repeat (6) apply_stimulus(1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h0000_0400, 1'b0);
    do_reset(2);
    inject_stale = 1'b1;
    lat_min = 1;
    lat_max = 1;
    repeat (10) apply_stimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] randomized traffic");
    salt      = $urandom;
    ready_pct = 70;
    lat_min   = 1;
    lat_max   = 4;
    for (int i = 0; i < 1500; i++) begin
      bit          stl;
      bit          rdr;
      logic [31:0] rpc;
      stl = ($urandom_range(99) < 30);
      rdr = ($urandom_range(99) < 3);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9) == 0) rpc = rpc | 32'hFFFF_FFE0;
      apply_stimulus(rdr, rpc, stl);
    end

    ready_pct = 100;
    lat_min   = 1;
    lat_max   = 1;
    repeat (20) apply_stimulus(1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
